// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register width, MDU latencies, Tuse/Tnew encodings
// and the register-dependency hazard check used by the stall controller.
package pipe_pkg;

  localparam int REG_W       = 5;
  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Tnew as produced by the decoder: cycles until the result is forwardable.
  typedef enum logic [1:0] {
    TNEW_0 = 2'd0,
    TNEW_1 = 2'd1,
    TNEW_2 = 2'd2,
    TNEW_3 = 2'd3
  } tnew_e;

  // A source read in D conflicts with a producer if the producer's result
  // arrives later than the consumer needs it; $zero and unused operands never do.
  function automatic logic dep_hazard(input logic [REG_W-1:0] src,
                                      input logic [1:0]       tuse,
                                      input logic [REG_W-1:0] dst,
                                      input tnew_e            tnew);
    return (src != '0) && (tuse != TUSE_NONE) && (src == dst) && (tuse < 2'(tnew));
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Multiply/divide occupancy counter: loads on an MDU start in E, counts down,
// holds while the pipeline is frozen, and reports md_busy.
module md_busy_counter
  import pipe_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start_E,
  input  logic md_div_E,
  input  logic freeze,
  output logic md_busy
);

  localparam int CW = $clog2(DIV_CYC + 1);

  logic [CW-1:0] md_cnt_q, md_cnt_d;

  // A start while the unit is already counting is ignored, not a reload.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (!freeze) begin
      if (md_start_E && (md_cnt_q == '0)) begin
        md_cnt_d = md_div_E ? CW'(DIV_CYC) : CW'(MULT_CYC);
      end else if (md_cnt_q != '0) begin
        md_cnt_d = md_cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) md_cnt_q <= '0;
    else        md_cnt_q <= md_cnt_d;
  end

  assign md_busy = reset & (md_start_E | (md_cnt_q != '0));

endmodule

// File: rtl/stall_ctrl.sv
// Five-stage pipeline hazard/stall controller: stage load enables, D/E flush,
// MDU busy tracking and a saturating stall-cycle counter.
module stall_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs_D,
  input  logic [REG_W-1:0] rt_D,
  input  logic [1:0]       tuse_rs_D,
  input  logic [1:0]       tuse_rt_D,
  input  logic             md_D,
  input  logic [REG_W-1:0] dst_E,
  input  logic [REG_W-1:0] dst_M,
  input  logic [1:0]       tnew_E,
  input  logic [1:0]       tnew_M,
  input  logic             md_start_E,
  input  logic             md_div_E,
  input  logic             freeze,
  output logic             en_PC,
  output logic             en_FD,
  output logic             en_DE,
  output logic             en_EM,
  output logic             en_MW,
  output logic             flush_DE,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic stall_rs, stall_rt, stall_md, stall_D;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  md_busy_counter #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_busy (
    .clk        (clk),
    .reset      (reset),
    .md_start_E (md_start_E),
    .md_div_E   (md_div_E),
    .freeze     (freeze),
    .md_busy    (md_busy)
  );

  assign stall_rs = dep_hazard(rs_D, tuse_rs_D, dst_E, tnew_e'(tnew_E)) |
                    dep_hazard(rs_D, tuse_rs_D, dst_M, tnew_e'(tnew_M));
  assign stall_rt = dep_hazard(rt_D, tuse_rt_D, dst_E, tnew_e'(tnew_E)) |
                    dep_hazard(rt_D, tuse_rt_D, dst_M, tnew_e'(tnew_M));
  assign stall_md = md_D & md_busy;
  assign stall_D  = stall_rs | stall_rt | stall_md;

  // Reset forces a free-running pipeline; freeze outranks any stall.
  always_comb begin
    en_PC    = 1'b1;
    en_FD    = 1'b1;
    en_DE    = 1'b1;
    en_EM    = 1'b1;
    en_MW    = 1'b1;
    flush_DE = 1'b0;
    if (reset) begin
      if (freeze) begin
        en_PC = 1'b0;
        en_FD = 1'b0;
        en_DE = 1'b0;
        en_EM = 1'b0;
        en_MW = 1'b0;
      end else begin
        en_PC    = ~stall_D;
        en_FD    = ~stall_D;
        flush_DE = stall_D;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!freeze && stall_D) stall_cnt_d = sat_inc(stall_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Randomized and directed bench for stall_ctrl with a cycle-deadline reference
// model feeding an expectation queue that a negedge monitor drains.
module tb_stall_ctrl;

  localparam int MULT = 5;
  localparam int DIV  = 10;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs_D, rt_D, dst_E, dst_M;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
  logic md_D, md_start_E, md_div_E, freeze;
  logic en_PC, en_FD, en_DE, en_EM, en_MW, flush_DE, md_busy;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  stall_ctrl #(.MULT_CYC(MULT), .DIV_CYC(DIV), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .rs_D(rs_D), .rt_D(rt_D),
    .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D), .md_D(md_D),
    .dst_E(dst_E), .dst_M(dst_M), .tnew_E(tnew_E), .tnew_M(tnew_M),
    .md_start_E(md_start_E), .md_div_E(md_div_E), .freeze(freeze),
    .en_PC(en_PC), .en_FD(en_FD), .en_DE(en_DE), .en_EM(en_EM), .en_MW(en_MW),
    .flush_DE(flush_DE), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [6:0]    ctl;   // en_PC,en_FD,en_DE,en_EM,en_MW,flush_DE,md_busy
    logic [CW-1:0] cnt;
    logic          chk_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Reference state: the MDU is busy through cycle busy_until.
  int cyc = 0;
  int busy_until = -1;
  int exp_cnt = 0;

  function automatic bit dep(input int src, input int tuse, input int dst, input int tnew);
    return src != 0 && tuse != 3 && src == dst && tuse < tnew;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e = exp_q.pop_front();
      act = {en_PC, en_FD, en_DE, en_EM, en_MW, flush_DE, md_busy};
      n_total++;
      if (act === e.ctl) n_pass++;
      else $display("FAIL outputs: got %b expected %b", act, e.ctl);
      if (e.chk_cnt) begin
        n_total++;
        if (stall_cnt === e.cnt) n_pass++;
        else $display("FAIL stall_cnt: got %0d expected %0d", stall_cnt, e.cnt);
      end
    end
  end

  task automatic cyc_begin();
    @(posedge clk);
    #1;
    reset = 1'b1; rs_D = '0; rt_D = '0; tuse_rs_D = 2'd3; tuse_rt_D = 2'd3;
    md_D = 1'b0; dst_E = '0; dst_M = '0; tnew_E = '0; tnew_M = '0;
    md_start_E = 1'b0; md_div_E = 1'b0; freeze = 1'b0;
  endtask

  task automatic cyc_end();
    exp_t e;
    bit busy, stall;
    busy  = reset && (md_start_E || cyc <= busy_until);
    stall = dep(rs_D, tuse_rs_D, dst_E, tnew_E) || dep(rs_D, tuse_rs_D, dst_M, tnew_M) ||
            dep(rt_D, tuse_rt_D, dst_E, tnew_E) || dep(rt_D, tuse_rt_D, dst_M, tnew_M) ||
            (md_D && busy);
    if (!reset)      e.ctl = 7'b1111100;
    else if (freeze) e.ctl = {6'b000000, busy};
    else             e.ctl = {!stall, !stall, 3'b111, stall, busy};
    e.cnt = CW'(exp_cnt);
    e.chk_cnt = (cyc != 0);
    exp_q.push_back(e);
    if (!reset) begin
      busy_until = cyc;
      exp_cnt = 0;
    end else if (freeze) begin
      if (cyc <= busy_until) busy_until++;
    end else begin
      if (md_start_E && !(cyc <= busy_until)) busy_until = cyc + (md_div_E ? DIV : MULT);
      if (stall && exp_cnt < CMAX) exp_cnt++;
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      cyc_begin(); reset = 1'b0; md_start_E = 1'b1; md_div_E = i[0]; cyc_end();
    end
  endtask

  initial begin
    reset = 1'b0; rs_D = '0; rt_D = '0; tuse_rs_D = 2'd3; tuse_rt_D = 2'd3;
    md_D = 1'b0; dst_E = '0; dst_M = '0; tnew_E = '0; tnew_M = '0;
    md_start_E = 1'b0; md_div_E = 1'b0; freeze = 1'b0;

    // reset with md_start_E high, then idle
    do_reset(2);
    cyc_begin(); cyc_end();
    #2 check("cnt_after_reset", stall_cnt, 0);

    // load-use followed by forwardable M result
    cyc_begin(); dst_E = 5'd8; tnew_E = 2'd2; rs_D = 5'd8; tuse_rs_D = 2'd1; cyc_end();
    cyc_begin(); dst_M = 5'd8; tnew_M = 2'd1; rs_D = 5'd8; tuse_rs_D = 2'd1; cyc_end();
    #2 check("cnt_load_use", stall_cnt, 1);

    // no false stalls: $zero source, unused operand
    cyc_begin(); rs_D = '0; dst_E = '0; tnew_E = 2'd2; tuse_rs_D = 2'd1; cyc_end();
    cyc_begin(); rt_D = 5'd5; dst_E = 5'd5; tnew_E = 2'd2; tuse_rt_D = 2'd3; cyc_end();

    // mult then mfhi held in D
    do_reset(1);
    for (int i = 0; i <= MULT + 1; i++) begin
      cyc_begin(); md_D = 1'b1; md_start_E = (i == 0); md_div_E = 1'b0; cyc_end();
    end
    #2 check("cnt_mult", stall_cnt, MULT + 1);

    // div with freeze in cycles 3-4, md_D held
    do_reset(1);
    for (int i = 0; i <= DIV + 3; i++) begin
      cyc_begin(); md_D = 1'b1; md_start_E = (i == 0); md_div_E = 1'b1;
      freeze = (i == 3 || i == 4); cyc_end();
      if (i == DIV + 2) #2 check("div_busy_end", md_busy, 1);
      if (i == DIV + 3) #2 check("div_busy_clear", md_busy, 0);
    end
    #1 check("cnt_div_freeze", stall_cnt, DIV + 1);

    // reset mid-div, then md_D proceeds
    do_reset(1);
    for (int i = 0; i < 7; i++) begin
      cyc_begin(); md_start_E = (i == 0); md_div_E = 1'b1;
      reset = (i != 4); md_D = (i >= 5); cyc_end();
    end

    // randomized traffic, saturating the narrow stall counter
    for (int i = 0; i < 800; i++) begin
      cyc_begin();
      reset      = ($urandom_range(0, 59) != 0);
      rs_D       = 5'($urandom_range(0, 3));
      rt_D       = 5'($urandom_range(0, 3));
      tuse_rs_D  = 2'($urandom_range(0, 3));
      tuse_rt_D  = 2'($urandom_range(0, 3));
      dst_E      = 5'($urandom_range(0, 3));
      dst_M      = 5'($urandom_range(0, 3));
      tnew_E     = 2'($urandom_range(0, 3));
      tnew_M     = 2'($urandom_range(0, 3));
      md_D       = ($urandom_range(0, 2) == 0);
      md_start_E = ($urandom_range(0, 5) == 0);
      md_div_E   = $urandom_range(0, 1) != 0;
      freeze     = ($urandom_range(0, 7) == 0);
      cyc_end();
    end

    @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Hazard and stall controller for the five-stage pipeline. Each cycle it produces the load-enables for the PC, F/D, D/E, E/M and M/W stage registers and the flush for D/E. Stall decisions come from three sources: Tuse/Tnew register-dependency checks, a multi-cycle multiply/divide busy counter, and an external freeze request. The block also keeps a saturating count of stall cycles for performance measurement.

## Interface
Parameters:
- MULT_CYC, 5: extra busy cycles after a mult/multu starts in E.
- DIV_CYC, 10: extra busy cycles after a div/divu starts in E.
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low (0 = reset, sampled on the rising edge of clk).
- rs_D, rt_D  in  5 each  source register indices of the instruction in D.
- tuse_rs_D, tuse_rt_D  in  2 each  cycles until D needs rs/rt; 3 = operand not used.
- md_D  in  1  instruction in D is mult/div/mfhi/mflo/mthi/mtlo.
- dst_E, dst_M  in  5 each  destination register of the instruction in E/M; 0 = none.
- tnew_E, tnew_M  in  2 each  cycles until the E/M result can be forwarded.
- md_start_E  in  1  one-cycle pulse: a mult/div is in E this cycle.
- md_div_E  in  1  qualifies md_start_E; 1 = div/divu, 0 = mult/multu.
- freeze  in  1  external hold of the whole pipeline.
- en_PC, en_FD, en_DE, en_EM, en_MW  out  1 each  stage-register load enables.
- flush_DE  out  1  D/E register loads a bubble (all-zero IR).
- md_busy  out  1  the multiply/divide unit is occupied.
- stall_cnt  out  CNT_W  number of cycles in which stall_D was asserted; saturates at all-ones.

## Operation
- Dependency stall `stall_rs` asserts when rs_D != 0 and either:
  - rs_D == dst_E and tuse_rs_D < tnew_E, or
  - rs_D == dst_M and tuse_rs_D < tnew_M.
- `stall_rt` is the same check using rt_D and tuse_rt_D.
- Tuse = 3 never stalls.
- MDU counter `md_cnt` is `$clog2(DIV_CYC+1)` bits wide:
  - If md_start_E = 1 and md_cnt == 0, load DIV_CYC when md_div_E = 1, otherwise MULT_CYC.
  - Else if md_cnt != 0, decrement.
  - md_start_E while md_cnt != 0 is ignored; the counter is not reloaded.
- md_busy = md_start_E OR (md_cnt != 0).
- stall_md = md_D AND md_busy.
- stall_D = stall_rs OR stall_rt OR stall_md.
- When freeze = 0:
  - en_PC = en_FD = NOT stall_D.
  - flush_DE = stall_D.
  - en_DE = en_EM = en_MW = 1.
- When freeze = 1: all en_* = 0 and flush_DE = 0. md_cnt and stall_cnt hold. freeze takes priority over stall_D.
- stall_cnt increments by 1 in each non-frozen cycle with stall_D = 1, and stops at 2^CNT_W - 1.
- While reset = 0:
  - Outputs are forced: all en_* = 1, flush_DE = 0, md_busy = 0.
  - md_start_E is ignored.
  - On the edge, md_cnt and stall_cnt are cleared to 0.
- Reset asserted mid-multiply abandons the count. md_busy = 0 from the first cycle of reset.

## Timing
- All outputs except stall_cnt are combinational from the inputs and md_cnt; there is no added latency.
- stall_cnt reflects the previous cycle: it updates on the edge at the end of each stalled cycle.
- A mult entering E in cycle t makes md_busy = 1 in cycles t through t+MULT_CYC, then 0 in cycle t+MULT_CYC+1. A div behaves the same with DIV_CYC.
- An md_D instruction in D during cycle t (with the mult in E) stalls for MULT_CYC+1 cycles and advances on the edge ending cycle t+MULT_CYC+1.
- A load in E (tnew_E = 2) followed by a dependent ALU op in D (tuse = 1) causes a one-cycle stall, after which tnew_M = 1 clears it.
- freeze for N cycles extends any pending MDU busy window by exactly N cycles.

## Structure
- Shared package pipe_pkg holds:
  - MULT_CYC and DIV_CYC defaults.
  - TUSE_NONE = 2'd3.
  - REG_W = 5.
  - The tnew encoding used by the decoder.
- Sub-module md_busy_counter contains md_cnt, its load/decrement logic, freeze hold and md_busy generation.
- The top level holds the comparators, the enable/flush muxing and stall_cnt.

## Test plan
- Reset: hold reset = 0 for 2 cycles with md_start_E = 1 → en_* = 1, flush_DE = 0, md_busy = 0. After release, stall_cnt = 0.
- Load-use: dst_E = 8, tnew_E = 2, rs_D = 8, tuse_rs_D = 1 → en_PC = en_FD = 0 and flush_DE = 1 for one cycle. Next cycle, with dst_M = 8 and tnew_M = 1, no stall. stall_cnt = 1.
- No false stall: rs_D = 0 with dst_E = 0 and tnew_E = 2 → no stall. tuse_rt_D = 3 with rt_D == dst_E → no stall.
- Mult then mfhi: md_start_E = 1, md_div_E = 0 at cycle 0, md_D = 1 held → stall in cycles 0–5, en_FD = 1 in cycle 6, stall_cnt = 6.
- Div with freeze: div starts at cycle 0, freeze = 1 in cycles 3–4 → md_busy deasserts in cycle 13. All enables are 0 and flush_DE = 0 during the freeze. stall_cnt does not count frozen cycles.
- Reset mid-div: reset = 0 at cycle 4 of a div → md_busy = 0 immediately. After release, md_D proceeds without a stall.
